instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the instruction decoder.
- Holds the program counter and issues word reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words in a 2-entry queue and presents {instruction, PC} to the decoder under a valid/ready handshake.
- Accepts branch/jump redirects from the execute side; a jump target is formed from the 26-bit J-type index field.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue.sv | 73 +++++++
 rtl/instr_fetch_unit.sv | 96 +++++++++
 tb/tb_instr_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned       INSTR_W   = 32;
   localparam logic [31:0]       RESET_PC  = 32'h0000_0000;
   localparam int unsigned       PC_INC    = 4;
   localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

   // J-type target: upper nibble of the jump's successor PC, then the word index.
   function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                               input logic [25:0] index);
      logic [31:0] pc_plus4;
      pc_plus4 = pc + 32'(PC_INC);
      return {pc_plus4[31:28], index, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {instruction, pc} with flush; flush beats push and pop.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push_i,
   input  logic [INSTR_W-1:0] push_instr_i,
   input  logic [ADDR_W-1:0]  push_pc_i,
   input  logic               pop_i,
   input  logic               flush_i,
   output logic [INSTR_W-1:0] head_instr_o,
   output logic [ADDR_W-1:0]  head_pc_o,
   output logic [1:0]         count_o,
   output logic               empty_o,
   output logic               full_o
);

   logic [INSTR_W-1:0] instr_q [2];
   logic [ADDR_W-1:0]  pc_q    [2];
   logic               rd_ptr_q, wr_ptr_q;
   logic [1:0]         count_q, count_d;
   logic               do_push, do_pop;

   assign do_push = push_i && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 2'd1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 2'd1;
      end
   end

   // NOTE: storage is reset (only two entries) so the head reads 0 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            instr_q[i] <= NOP_INSTR;
            pc_q[i]    <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            instr_q[wr_ptr_q] <= push_instr_i;
            pc_q[wr_ptr_q]    <= push_pc_i;
            wr_ptr_q          <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   assign head_instr_o = instr_q[rd_ptr_q];
   assign head_pc_o    = pc_q[rd_ptr_q];
   assign count_o      = count_q;
   assign empty_o      = (count_q == 2'd0);
   assign full_o       = (count_q == 2'd2);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, 1-cycle-latency imem reads, 2-entry output queue
// toward the decoder, and branch/jump redirect handling.
module instr_fetch_unit #(
   parameter int unsigned       ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = fetch_pkg::RESET_PC,
   parameter int unsigned       FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic              instr_valid,
   input  logic              dec_ready,
   input  logic              branch_en,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump_en,
   input  logic [25:0]       jump_index,
   input  logic [ADDR_W-1:0] jump_pc
);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] tag_q;
   logic [ADDR_W-1:0] redirect_pc;
   logic              inflight_q;
   logic              redirect, pop;
   logic [1:0]        q_count;
   logic              q_empty, q_full;
   logic [2:0]        slots_used;

   assign redirect = branch_en || jump_en;

   always_comb begin
      if (branch_en) begin
         redirect_pc = {branch_target[ADDR_W-1:2], 2'b00};
      end else begin
         redirect_pc = ADDR_W'(fetch_pkg::jump_target(32'(jump_pc), jump_index));
      end
   end

   assign instr_valid = !q_empty;
   assign pop         = instr_valid && dec_ready;

   // An entry leaving this cycle frees its slot now, which sustains one fetch per cycle.
   assign slots_used = {1'b0, q_count} - {2'b00, pop} + {2'b00, inflight_q};
   assign imem_req   = rst_n && !redirect && (slots_used < 3'(FIFO_DEPTH));
   assign imem_addr  = fetch_pc_q;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
      end else if (imem_req) begin
         fetch_pc_d = fetch_pc_q + ADDR_W'(fetch_pkg::PC_INC);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         inflight_q <= 1'b0;
         tag_q      <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= imem_req;
         if (imem_req) begin
            tag_q <= fetch_pc_q;
         end
      end
   end

   // A response arriving during a redirect is squashed by the queue's flush priority.
   fetch_queue #(
      .ADDR_W (ADDR_W)
   ) u_queue (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (inflight_q),
      .push_instr_i (imem_rdata),
      .push_pc_i    (tag_q),
      .pop_i        (pop),
      .flush_i      (redirect),
      .head_instr_o (instr_out),
      .head_pc_o    (pc_out),
      .count_o      (q_count),
      .empty_o      (q_empty),
      .full_o       (q_full)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(q_full && inflight_q));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit with a 1-cycle imem model.
module tb_instr_fetch_unit;

   localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        instr_valid;
   logic        dec_ready = 1'b0;
   logic        branch_en = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        jump_en = 1'b0;
   logic [25:0] jump_index = 26'h0;
   logic [31:0] jump_pc = 32'h0;

   int n_checks = 0;
   int n_errors = 0;

   instr_fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .instr_out     (instr_out),
      .pc_out        (pc_out),
      .instr_valid   (instr_valid),
      .dec_ready     (dec_ready),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .jump_en       (jump_en),
      .jump_index    (jump_index),
      .jump_pc       (jump_pc)
   );

   always #5 clk = ~clk;

   // Synchronous memory: word = addr ^ pattern one cycle after a request, junk otherwise.
   always @(posedge clk) begin
      imem_rdata <= imem_req ? (imem_addr ^ XOR_PAT) : 32'hDEAD_BEEF;
   end

   typedef struct {
      logic        dr;
      logic        br;
      logic [31:0] bt;
      logic        jp;
      logic [31:0] jpc;
      logic [25:0] ji;
      logic        req;
      logic        vld;
      logic [31:0] pc;
   } vec_t;

   vec_t seg_a [33];
   vec_t seg_b [12];

   function automatic vec_t mk(input logic dr, input logic br, input logic [31:0] bt,
                               input logic jp, input logic [31:0] jpc, input logic [25:0] ji,
                               input logic req, input logic vld, input logic [31:0] pc);
      vec_t v;
      v.dr = dr; v.br = br; v.bt = bt; v.jp = jp; v.jpc = jpc; v.ji = ji;
      v.req = req; v.vld = vld; v.pc = pc;
      return v;
   endfunction

   function automatic vec_t pv(input logic dr, input logic req, input logic vld,
                               input logic [31:0] pc);
      return mk(dr, 1'b0, 32'h0, 1'b0, 32'h0, 26'h0, req, vld, pc);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      dec_ready     = v.dr;
      branch_en     = v.br;
      branch_target = v.bt;
      jump_en       = v.jp;
      jump_pc       = v.jpc;
      jump_index    = v.ji;
      #1;
      check({tag, " imem_req"}, 32'(imem_req), 32'(v.req));
      check({tag, " instr_valid"}, 32'(instr_valid), 32'(v.vld));
      if (v.vld) begin
         check({tag, " pc_out"}, pc_out, v.pc);
         check({tag, " instr_out"}, instr_out, v.pc ^ XOR_PAT);
      end
      if (imem_req) begin
         check({tag, " addr align"}, 32'(imem_addr[1:0]), 32'h0);
      end
   endtask

   task automatic run_a(input int lo, input int hi, input string name);
      for (int i = lo; i <= hi; i++) apply(seg_a[i], $sformatf("%s[%0d]", name, i));
   endtask

   task automatic idle_inputs();
      branch_en = 1'b0; jump_en = 1'b0;
      branch_target = 32'h0; jump_pc = 32'h0; jump_index = 26'h0;
   endtask

   task automatic check_zero(input string name);
      check({name, " instr_valid"}, 32'(instr_valid), 32'h0);
      check({name, " instr_out"}, instr_out, 32'h0);
      check({name, " pc_out"}, pc_out, 32'h0);
      check({name, " imem_req"}, 32'(imem_req), 32'h0);
   endtask

   // Long reset, then release at a falling edge; the following cycle is C0.
   task automatic full_reset(input string name);
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clk);
      #1;
      check_zero(name);
      @(negedge clk);
      rst_n = 1'b1;
      dec_ready = 1'b1;
      #1;
      check({name, " C0 imem_req"}, 32'(imem_req), 32'h1);
      check({name, " C0 imem_addr"}, imem_addr, 32'h0);
      check({name, " C0 instr_valid"}, 32'(instr_valid), 32'h0);
   endtask

   // Short reset pulse entirely between two rising edges.
   task automatic pulse_reset(input string name);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_zero(name);
      idle_inputs();
      dec_ready = 1'b1;
      #1 rst_n = 1'b1;
   endtask

   initial begin
      seg_a[0]  = pv(1, 1, 0, 32'h0);
      seg_a[1]  = pv(1, 1, 1, 32'h0);
      seg_a[2]  = pv(1, 1, 1, 32'h4);
      seg_a[3]  = pv(1, 1, 1, 32'h8);
      seg_a[4]  = pv(1, 1, 1, 32'hC);
      seg_a[5]  = mk(1, 1, 32'h0000_0103, 0, 32'h0, 26'h0, 0, 1, 32'h10);
      seg_a[6]  = pv(1, 1, 0, 32'h0);
      seg_a[7]  = pv(1, 1, 0, 32'h0);
      seg_a[8]  = pv(1, 1, 1, 32'h100);
      seg_a[9]  = pv(1, 1, 1, 32'h104);
      seg_a[10] = mk(1, 0, 32'h0, 1, 32'h1000_0040, 26'h000_0010, 0, 1, 32'h108);
      seg_a[11] = pv(1, 1, 0, 32'h0);
      seg_a[12] = pv(1, 1, 0, 32'h0);
      seg_a[13] = pv(1, 1, 1, 32'h1000_0040);
      seg_a[14] = pv(1, 1, 1, 32'h1000_0044);
      seg_a[15] = mk(1, 1, 32'h200, 1, 32'h1000_0040, 26'h000_0010, 0, 1, 32'h1000_0048);
      seg_a[16] = pv(1, 1, 0, 32'h0);
      seg_a[17] = pv(1, 1, 0, 32'h0);
      seg_a[18] = pv(1, 1, 1, 32'h200);
      seg_a[19] = pv(1, 1, 1, 32'h204);
      seg_a[20] = mk(1, 1, 32'hFFFF_FFF8, 0, 32'h0, 26'h0, 0, 1, 32'h208);
      seg_a[21] = pv(1, 1, 0, 32'h0);
      seg_a[22] = pv(1, 1, 0, 32'h0);
      seg_a[23] = pv(1, 1, 1, 32'hFFFF_FFF8);
      seg_a[24] = pv(1, 1, 1, 32'hFFFF_FFFC);
      seg_a[25] = pv(1, 1, 1, 32'h0);
      seg_a[26] = pv(1, 1, 1, 32'h4);
      seg_a[27] = mk(1, 1, 32'h300, 0, 32'h0, 26'h0, 0, 1, 32'h8);
      seg_a[28] = mk(1, 1, 32'h400, 0, 32'h0, 26'h0, 0, 0, 32'h0);
      seg_a[29] = pv(1, 1, 0, 32'h0);
      seg_a[30] = pv(1, 1, 0, 32'h0);
      seg_a[31] = pv(1, 1, 1, 32'h400);
      seg_a[32] = pv(1, 1, 1, 32'h404);

      seg_b[0]  = pv(0, 1, 0, 32'h0);
      seg_b[1]  = pv(0, 0, 1, 32'h0);
      seg_b[2]  = pv(0, 0, 1, 32'h0);
      seg_b[3]  = pv(0, 0, 1, 32'h0);
      seg_b[4]  = pv(0, 0, 1, 32'h0);
      seg_b[5]  = pv(0, 0, 1, 32'h0);
      seg_b[6]  = pv(1, 1, 1, 32'h0);
      seg_b[7]  = pv(1, 1, 1, 32'h4);
      seg_b[8]  = pv(1, 1, 1, 32'h8);
      seg_b[9]  = pv(1, 1, 1, 32'hC);
      seg_b[10] = pv(0, 0, 1, 32'h10);
      seg_b[11] = pv(0, 0, 1, 32'h10);

      // Streaming, branch, jump, branch-over-jump, wrap, back-to-back redirects.
      full_reset("rst1");
      run_a(0, 32, "stream");

      // Decoder stall fills the queue, then drains in order.
      full_reset("rst2");
      for (int i = 0; i < 12; i++) apply(seg_b[i], $sformatf("stall[%0d]", i));

      // Reset with a full queue, then reset with a response in flight.
      pulse_reset("rst_full");
      run_a(0, 3, "restart1");
      pulse_reset("rst_inflight");
      run_a(0, 3, "restart2");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
